// File: rtl/toggle_cover_arbiter.sv
// Toggle-coverage collector: sticky seen map, first-hit queue, round-robin drain to one reporter.
// Latency: hit sampled at t -> out_valid at t+2 earliest; out_index held stable while out_ready is low.
module toggle_cover_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int SRC_W      = 5,
    parameter int COVER_BASE = 0,
    parameter int IDX_W      = 32,
    parameter int CNT_W      = $clog2(NUM_SRC*SRC_W+1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_SRC*SRC_W-1:0] src_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic [CNT_W-1:0]         covered_count,
    output logic                     busy
);

    localparam int NPTS  = NUM_SRC*SRC_W;
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state;
    logic [NPTS-1:0]   seen;
    logic [NPTS-1:0]   pending;
    logic [NPTS-1:0]   new_hits;
    logic [NPTS-1:0]   load_mask;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  nxt_ptr;
    logic [IDX_W-1:0]  sel_index;
    logic [CNT_W-1:0]  new_cnt;
    logic              sel_found;
    logic              take;
    int                arb_s;

    // clear wins over any hit arriving in the same cycle
    always_comb begin
        new_hits = (enable && !clear) ? (src_valid & ~seen) : '0;
    end

    always_comb begin
        new_cnt = '0;
        for (int i = 0; i < NPTS; i++) begin
            new_cnt = new_cnt + CNT_W'(new_hits[i]);
        end
    end

    // First eligible source at or after rr_ptr; lowest pending bit inside it.
    always_comb begin
        sel_found = 1'b0;
        sel_index = '0;
        load_mask = '0;
        nxt_ptr   = '0;
        arb_s     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            arb_s = int'(rr_ptr) + k;
            if (arb_s >= NUM_SRC) begin
                arb_s = arb_s - NUM_SRC;
            end
            if (!sel_found && (|pending[arb_s*SRC_W +: SRC_W])) begin
                sel_found = 1'b1;
                nxt_ptr   = (arb_s == NUM_SRC-1) ? '0 : PTR_W'(arb_s + 1);
                for (int b = SRC_W-1; b >= 0; b--) begin
                    if (pending[arb_s*SRC_W + b]) begin
                        sel_index = IDX_W'(COVER_BASE + arb_s*SRC_W + b);
                        load_mask = '0;
                        load_mask[arb_s*SRC_W + b] = 1'b1;
                    end
                end
            end
        end
    end

    // A clear cycle never loads: the presented index completes, then the FSM idles.
    always_comb begin
        take = sel_found && !clear && ((state == IDLE) || out_ready);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            seen          <= '0;
            pending       <= '0;
            covered_count <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            rr_ptr        <= '0;
        end else begin
            if (clear) begin
                seen          <= '0;
                pending       <= '0;
                covered_count <= '0;
            end else begin
                seen          <= seen | new_hits;
                pending       <= (pending & ~(take ? load_mask : '0)) | new_hits;
                covered_count <= covered_count + new_cnt;
            end

            if (take) begin
                out_index <= sel_index;
                rr_ptr    <= nxt_ptr;
                out_valid <= 1'b1;
                state     <= HOLD;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

    always_comb begin
        busy = out_valid | (|pending);
    end

endmodule

// File: tb/tb_toggle_cover_arbiter.sv
// Bench for toggle_cover_arbiter: directed scenarios plus a random phase against a set-based model.
module tb_toggle_cover_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int SRC_W      = 5;
    localparam int COVER_BASE = 100;
    localparam int IDX_W      = 32;
    localparam int NPTS       = NUM_SRC*SRC_W;
    localparam int CNT_W      = $clog2(NPTS+1);

    logic              clock     = 1'b0;
    logic              reset     = 1'b0;
    logic              enable    = 1'b0;
    logic              clear     = 1'b0;
    logic              out_ready = 1'b0;
    logic [NPTS-1:0]   src_valid = '0;
    logic              out_valid;
    logic [IDX_W-1:0]  out_index;
    logic [CNT_W-1:0]  covered_count;
    logic              busy;

    toggle_cover_arbiter #(
        .NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .COVER_BASE(COVER_BASE), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .src_valid(src_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .covered_count(covered_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: sets of seen/pending points, the presented index, and the round-robin start source.
    bit m_seen [NPTS];
    bit m_pend [NPTS];
    bit m_valid;
    int m_index;
    int m_rr;
    int m_count;
    int beats[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int beat_at(input int i);
        return (i < beats.size()) ? beats[i] : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NPTS; i++) begin
            m_seen[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_index = 0;
        m_rr    = 0;
        m_count = 0;
    endtask

    task automatic model_step();
        int pick_pt;
        int pick_s;
        pick_pt = -1;
        pick_s  = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int s;
            s = (m_rr + k) % NUM_SRC;
            for (int b = 0; b < SRC_W; b++) begin
                if (pick_pt < 0 && m_pend[s*SRC_W + b]) begin
                    pick_pt = s*SRC_W + b;
                    pick_s  = s;
                end
            end
        end
        if (pick_pt >= 0 && !clear && (!m_valid || out_ready)) begin
            m_valid         = 1'b1;
            m_index         = COVER_BASE + pick_pt;
            m_pend[pick_pt] = 1'b0;
            m_rr            = (pick_s + 1) % NUM_SRC;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (clear) begin
            for (int i = 0; i < NPTS; i++) begin
                m_seen[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_count = 0;
        end else if (enable) begin
            for (int i = 0; i < NPTS; i++) begin
                if (src_valid[i] && !m_seen[i]) begin
                    m_seen[i] = 1'b1;
                    m_pend[i] = 1'b1;
                    m_count++;
                end
            end
        end
    endtask

    task automatic compare();
        bit any_pend;
        any_pend = 1'b0;
        for (int i = 0; i < NPTS; i++) any_pend |= m_pend[i];
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) chk("out_index", 64'(out_index), 64'(m_index));
        chk("covered_count", 64'(covered_count), 64'(m_count));
        chk("busy", 64'(busy), 64'(m_valid | any_pend));
    endtask

    task automatic tick();
        if (out_valid && out_ready) beats.push_back(int'(out_index));
        model_step();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic drive(input bit en, input bit clr, input logic [NPTS-1:0] sv, input bit rdy);
        enable    = en;
        clear     = clr;
        src_valid = sv;
        out_ready = rdy;
    endtask

    task automatic idle_ticks(input int n, input bit rdy);
        drive(1'b1, 1'b0, '0, rdy);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(covered_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        beats.delete();
    endtask

    initial begin
        logic [NPTS-1:0] v;

        // 1: single hit on bit 7
        do_reset();
        drive(1'b1, 1'b0, NPTS'(1) << 7, 1'b1);
        tick();
        idle_ticks(5, 1'b1);
        chk("t1_nbeats", 64'(beats.size()), 64'd1);
        chk("t1_idx", 64'(beat_at(0)), 64'd107);
        chk("t1_count", 64'(covered_count), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);

        // 2: bit 7 held for 10 cycles
        do_reset();
        drive(1'b1, 1'b0, NPTS'(1) << 7, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        idle_ticks(4, 1'b1);
        chk("t2_nbeats", 64'(beats.size()), 64'd1);
        chk("t2_idx", 64'(beat_at(0)), 64'd107);
        chk("t2_count", 64'(covered_count), 64'd1);

        // 3: simultaneous hits on several sources
        do_reset();
        v = '0;
        v[0] = 1'b1; v[5] = 1'b1; v[6] = 1'b1; v[15] = 1'b1;
        drive(1'b1, 1'b0, v, 1'b1);
        tick();
        idle_ticks(7, 1'b1);
        chk("t3_nbeats", 64'(beats.size()), 64'd4);
        chk("t3_b0", 64'(beat_at(0)), 64'd100);
        chk("t3_b1", 64'(beat_at(1)), 64'd105);
        chk("t3_b2", 64'(beat_at(2)), 64'd115);
        chk("t3_b3", 64'(beat_at(3)), 64'd106);
        chk("t3_count", 64'(covered_count), 64'd4);

        // 4: backpressure with two pending
        do_reset();
        v = '0;
        v[0] = 1'b1; v[1] = 1'b1;
        drive(1'b1, 1'b0, v, 1'b0);
        tick();
        idle_ticks(5, 1'b0);
        chk("t4_hold_valid", 64'(out_valid), 64'd1);
        chk("t4_hold_idx", 64'(out_index), 64'd100);
        idle_ticks(4, 1'b1);
        chk("t4_nbeats", 64'(beats.size()), 64'd2);
        chk("t4_b0", 64'(beat_at(0)), 64'd100);
        chk("t4_b1", 64'(beat_at(1)), 64'd101);

        // 5: clear while 105 is presented, with a same-cycle hit on bit 2
        do_reset();
        v = '0;
        v[5] = 1'b1; v[10] = 1'b1;
        drive(1'b1, 1'b0, v, 1'b0);
        tick();
        idle_ticks(2, 1'b0);
        chk("t5_pres", 64'(out_index), 64'd105);
        drive(1'b1, 1'b1, NPTS'(1) << 2, 1'b1);
        tick();
        idle_ticks(5, 1'b1);
        chk("t5_nbeats", 64'(beats.size()), 64'd1);
        chk("t5_b0", 64'(beat_at(0)), 64'd105);
        chk("t5_count", 64'(covered_count), 64'd0);
        drive(1'b1, 1'b0, NPTS'(1) << 5, 1'b1);
        tick();
        idle_ticks(4, 1'b1);
        chk("t5_nbeats2", 64'(beats.size()), 64'd2);
        chk("t5_b1", 64'(beat_at(1)), 64'd105);

        // 6: reset asserted while holding an index
        do_reset();
        drive(1'b1, 1'b0, NPTS'(1) << 7, 1'b0);
        tick();
        idle_ticks(3, 1'b0);
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_count", 64'(covered_count), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        beats.delete();
        drive(1'b1, 1'b0, NPTS'(1) << 7, 1'b1);
        tick();
        idle_ticks(4, 1'b1);
        chk("t6_nbeats", 64'(beats.size()), 64'd1);
        chk("t6_b0", 64'(beat_at(0)), 64'd107);

        // random phase against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NPTS; i++) v[i] = ($urandom_range(15) == 0);
            drive($urandom_range(7) != 0, $urandom_range(63) == 0, v, $urandom_range(3) != 0);
            tick();
        end
        idle_ticks(40, 1'b1);
        chk("rand_drained", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
